// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the 32-bit bus datapath: fetch, memory wait,
// decode and per-opcode micro-sequences. Outputs decode state_q and ir (plus
// mem_ready for the MDRin strobe in read-wait ready cycles).
module control_sequencer #(
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT,
  output logic        run,
  output logic        illegal
);

  localparam int unsigned REG_N = 16;
  localparam int unsigned OP_N  = 13;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU3, C_MULDIV, C_UNARY, C_LD, C_ST, C_NOP, C_HALT, C_ILL
  } class_t;

  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic              illegal_q, illegal_d;
  class_t            cls;
  logic [OP_N-1:0]   op_oh;
  logic [OP_N-1:0]   alu;
  logic [4:0]        opc;
  logic [REG_N-1:0]  ra_oh, rb_oh, rc_oh;
  logic              unused_ir;

  assign opc       = ir[31:27];
  assign ra_oh     = REG_N'(1) << ir[26:23];
  assign rb_oh     = REG_N'(1) << ir[22:19];
  assign rc_oh     = REG_N'(1) << ir[18:15];
  assign unused_ir = ^ir[14:0];

  // Opcode class and one-hot ALU op (bit 12 = ADD ... bit 0 = NOT)
  always_comb begin
    cls   = HALT_ON_ILLEGAL ? C_ILL : C_NOP;
    op_oh = '0;
    case (opc)
      5'd0:  cls = C_LD;
      5'd2:  cls = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        cls   = C_ALU3;
        op_oh = OP_N'(13'h1000 >> (opc - 5'd3));
      end
      5'd15, 5'd16: begin
        cls   = C_MULDIV;
        op_oh = OP_N'(13'h0008 >> (opc - 5'd15));
      end
      5'd17, 5'd18: begin
        cls   = C_UNARY;
        op_oh = OP_N'(13'h0002 >> (opc - 5'd17));
      end
      5'd26:   cls = C_NOP;
      5'd27:   cls = C_HALT;
      default: ;
    endcase
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_RESET;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and control strobe decode
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    first_d   = (state_q == S_T0);
    reg_in    = '0;
    reg_out   = '0;
    PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu     = '0;
    run     = (state_q != S_RESET) && (state_q != S_HALT);
    illegal = (state_q == S_HALT) && illegal_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = first_q; Read = 1'b1;
        if (mem_ready) begin
          MDRin   = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (cls)
          C_ALU3, C_LD, C_ST: begin reg_out = rb_oh; Yin = 1'b1; end
          C_MULDIV:           begin reg_out = ra_oh; Yin = 1'b1; end
          C_UNARY:            begin reg_out = rb_oh; alu = op_oh; Zin = 1'b1; end
          C_NOP:              state_d = S_T0;
          C_HALT:             begin state_d = S_HALT; illegal_d = 1'b0; end
          default:            begin state_d = S_HALT; illegal_d = 1'b1; end
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          C_ALU3:       begin reg_out = rc_oh; alu = op_oh; Zin = 1'b1; end
          C_MULDIV:     begin reg_out = rb_oh; alu = op_oh; Zin = 1'b1; end
          C_UNARY:      begin Zlowout = 1'b1; reg_in = ra_oh; state_d = S_T0; end
          C_LD, C_ST:   begin Cout = 1'b1; alu = OP_N'(13'h1000); Zin = 1'b1; end
          default:      state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (cls)
          C_ALU3:     begin Zlowout = 1'b1; reg_in = ra_oh; state_d = S_T0; end
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          default:    state_d = S_T0;
        endcase
      end
      S_T6: begin
        state_d = S_T0;
        case (cls)
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          C_LD: begin
            Read    = 1'b1;
            state_d = S_T6;
            if (mem_ready) begin
              MDRin   = 1'b1;
              state_d = S_T7;
            end
          end
          C_ST:    begin reg_out = ra_oh; MDRin = 1'b1; state_d = S_T7; end
          default: ;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        case (cls)
          C_LD: begin MDRout = 1'b1; reg_in = ra_oh; end
          C_ST: begin
            Write = 1'b1;
            if (!mem_ready) state_d = S_T7;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT} = alu;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: micro-step list reference model
// compared every cycle, plus literal expectations for the named scenarios.
module tb_control_sequencer;

  localparam int P_PCIN = 13, P_PCOUT = 12, P_IRIN = 11, P_YIN = 10, P_ZIN = 9;
  localparam int P_MARIN = 8, P_MDRIN = 7, P_MDROUT = 6, P_HIIN = 5, P_LOIN = 4;
  localparam int P_INCPC = 3, P_ZHI = 2, P_ZLO = 1, P_COUT = 0;
  localparam bit M_HALT_ILL = 1'b1;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [13:0] s;
    logic        rd;
    logic        wr;
    logic [12:0] alu;
    logic        run;
    logic        ill;
  } ctl_t;

  // wk: 0 = single cycle, 1 = read wait, 2 = write wait; ha: 1 halt, 2 illegal halt
  typedef struct {
    ctl_t c;
    int   wk;
    int   ha;
  } step_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = 32'h18918000;
  logic        mem_ready = 1'b1;

  logic [15:0] reg_in, reg_out;
  logic PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin, IncPC;
  logic Zhighout, Zlowout, Cout, Read, Write;
  logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
  logic run, illegal;

  logic [15:0] n_reg_in, n_reg_out;
  logic [13:0] n_s;
  logic [12:0] n_alu;
  logic        n_rd, n_wr, n_run, n_ill;

  ctl_t dv;
  assign dv = {reg_in, reg_out, PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout,
               HIin, LOin, IncPC, Zhighout, Zlowout, Cout, Read, Write,
               ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
               run, illegal};

  always #5 clk = ~clk;

  control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .reg_in(reg_in), .reg_out(reg_out),
    .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout), .Read(Read), .Write(Write),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT),
    .run(run), .illegal(illegal)
  );

  control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .reg_in(n_reg_in), .reg_out(n_reg_out),
    .PCin(n_s[13]), .PCout(n_s[12]), .IRin(n_s[11]), .Yin(n_s[10]), .Zin(n_s[9]),
    .MARin(n_s[8]), .MDRin(n_s[7]), .MDRout(n_s[6]), .HIin(n_s[5]), .LOin(n_s[4]),
    .IncPC(n_s[3]), .Zhighout(n_s[2]), .Zlowout(n_s[1]), .Cout(n_s[0]),
    .Read(n_rd), .Write(n_wr),
    .ADD(n_alu[12]), .SUB(n_alu[11]), .AND(n_alu[10]), .OR(n_alu[9]), .SHR(n_alu[8]),
    .SHRA(n_alu[7]), .SHL(n_alu[6]), .ROR(n_alu[5]), .ROL(n_alu[4]), .MUL(n_alu[3]),
    .DIV(n_alu[2]), .NEG(n_alu[1]), .NOT(n_alu[0]),
    .run(n_run), .illegal(n_ill)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: 0 = RESET, 1 = running a step list, 2 = HALT
  int    m_mode = 0;
  bit    m_ill = 1'b0;
  bit    m_first = 1'b1;
  bit    m_fetch = 1'b1;
  step_t m_q[$];

  function automatic logic [13:0] sb(input int b);
    return 14'h1 << b;
  endfunction

  function automatic step_t mk(input logic [15:0] rin, input logic [15:0] rout,
                               input logic [13:0] s, input logic rd, input logic wr,
                               input int alub, input int wk, input int ha);
    step_t t;
    t.c      = '0;
    t.c.rin  = rin;
    t.c.rout = rout;
    t.c.s    = s;
    t.c.rd   = rd;
    t.c.wr   = wr;
    if (alub >= 0) t.c.alu = 13'h1 << alub;
    t.wk = wk;
    t.ha = ha;
    return t;
  endfunction

  function automatic void load_fetch();
    m_q.delete();
    m_q.push_back(mk('0, '0, sb(P_PCOUT) | sb(P_MARIN) | sb(P_INCPC) | sb(P_ZIN), 1'b0, 1'b0, -1, 0, 0));
    m_q.push_back(mk('0, '0, sb(P_ZLO) | sb(P_PCIN), 1'b1, 1'b0, -1, 1, 0));
    m_q.push_back(mk('0, '0, sb(P_MDROUT) | sb(P_IRIN), 1'b0, 1'b0, -1, 0, 0));
    m_fetch = 1'b1;
    m_first = 1'b1;
  endfunction

  function automatic void build_exec(input logic [31:0] v);
    int          opc;
    logic [15:0] a, b, c;
    opc = int'(v[31:27]);
    a = 16'h1 << v[26:23];
    b = 16'h1 << v[22:19];
    c = 16'h1 << v[18:15];
    m_fetch = 1'b0;
    if (opc >= 3 && opc <= 11) begin
      m_q.push_back(mk('0, b, sb(P_YIN), 1'b0, 1'b0, -1, 0, 0));
      m_q.push_back(mk('0, c, sb(P_ZIN), 1'b0, 1'b0, 15 - opc, 0, 0));
      m_q.push_back(mk(a, '0, sb(P_ZLO), 1'b0, 1'b0, -1, 0, 0));
    end else if (opc == 15 || opc == 16) begin
      m_q.push_back(mk('0, a, sb(P_YIN), 1'b0, 1'b0, -1, 0, 0));
      m_q.push_back(mk('0, b, sb(P_ZIN), 1'b0, 1'b0, 18 - opc, 0, 0));
      m_q.push_back(mk('0, '0, sb(P_ZLO) | sb(P_LOIN), 1'b0, 1'b0, -1, 0, 0));
      m_q.push_back(mk('0, '0, sb(P_ZHI) | sb(P_HIIN), 1'b0, 1'b0, -1, 0, 0));
    end else if (opc == 17 || opc == 18) begin
      m_q.push_back(mk('0, b, sb(P_ZIN), 1'b0, 1'b0, 18 - opc, 0, 0));
      m_q.push_back(mk(a, '0, sb(P_ZLO), 1'b0, 1'b0, -1, 0, 0));
    end else if (opc == 0 || opc == 2) begin
      m_q.push_back(mk('0, b, sb(P_YIN), 1'b0, 1'b0, -1, 0, 0));
      m_q.push_back(mk('0, '0, sb(P_COUT) | sb(P_ZIN), 1'b0, 1'b0, 12, 0, 0));
      m_q.push_back(mk('0, '0, sb(P_ZLO) | sb(P_MARIN), 1'b0, 1'b0, -1, 0, 0));
      if (opc == 0) begin
        m_q.push_back(mk('0, '0, '0, 1'b1, 1'b0, -1, 1, 0));
        m_q.push_back(mk(a, '0, sb(P_MDROUT), 1'b0, 1'b0, -1, 0, 0));
      end else begin
        m_q.push_back(mk('0, a, sb(P_MDRIN), 1'b0, 1'b0, -1, 0, 0));
        m_q.push_back(mk('0, '0, '0, 1'b0, 1'b1, -1, 2, 0));
      end
    end else if (opc == 26) begin
      m_q.push_back(mk('0, '0, '0, 1'b0, 1'b0, -1, 0, 0));
    end else if (opc == 27) begin
      m_q.push_back(mk('0, '0, '0, 1'b0, 1'b0, -1, 0, 1));
    end else begin
      m_q.push_back(mk('0, '0, '0, 1'b0, 1'b0, -1, 0, M_HALT_ILL ? 2 : 0));
    end
  endfunction

  // Advance the model across one rising edge using the inputs the DUT sampled
  function automatic void model_adv();
    int ha;
    if (clr) begin
      m_mode = 0;
      m_ill  = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      load_fetch();
    end else if (m_mode == 1) begin
      if (m_q[0].wk != 0 && !mem_ready) begin
        m_first = 1'b0;
      end else begin
        ha = m_q[0].ha;
        void'(m_q.pop_front());
        m_first = 1'b1;
        if (ha != 0) begin
          m_mode = 2;
          m_ill  = (ha == 2);
        end else if (m_q.size() == 0) begin
          if (m_fetch) build_exec(ir);
          else load_fetch();
        end
      end
    end
  endfunction

  function automatic ctl_t model_exp();
    ctl_t e;
    e = '0;
    if (m_mode == 2) begin
      e.ill = m_ill;
    end else if (m_mode == 1) begin
      e = m_q[0].c;
      e.run = 1'b1;
      if (m_q[0].wk == 1) begin
        if (!m_first) e.s[P_PCIN] = 1'b0;
        if (mem_ready) e.s[P_MDRIN] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // One clock: edge, model update, drive inputs, compare on the falling edge
  task automatic step(input logic c, input logic mr);
    ctl_t e;
    @(posedge clk);
    model_adv();
    #1;
    clr       = c;
    mem_ready = mr;
    @(negedge clk);
    cyc++;
    e = model_exp();
    total++;
    if (dv !== e) begin
      bad++;
      $display("FAIL model_cmp at cycle %0d: got %h expected %h", cyc, dv, e);
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] ok [17];
    logic [4:0] opc;
    ok = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
           5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
    if ($urandom_range(0, 4) == 0) opc = 5'($urandom_range(0, 31));
    else opc = ok[$urandom_range(0, 16)];
    return {opc, 27'($urandom())};
  endfunction

  initial begin
    int rd_n, pc_n, md_n, wr_n, hc;
    logic c;

    // Reset held two cycles, then one RESET cycle with clr low, then fetch
    step(1'b1, 1'b1);
    chk("rst_zero_a", 32'(dv != '0), 0);
    step(1'b0, 1'b1);
    chk("rst_zero_b", 32'(dv != '0), 0);
    step(1'b0, 1'b1);
    chk("t0_strobes", {18'b0, PCout, MARin, IncPC, Zin, dv.s}, {18'b0, 4'b1111, 14'h1308});
    chk("t0_run", run, 1);

    // add R1,R2,R3 with memory always ready
    step(1'b0, 1'b1);
    chk("add_t1", {Read, PCin, MDRin, Zlowout}, 4'b1111);
    step(1'b0, 1'b1);
    chk("add_t2", {MDRout, IRin}, 2'b11);
    step(1'b0, 1'b1);
    chk("add_t3_rout", reg_out, 32'h0004);
    chk("add_t3_yin", Yin, 1);
    step(1'b0, 1'b1);
    chk("add_t4", {reg_out, ADD, Zin}, {16'h0008, 2'b11});
    step(1'b0, 1'b1);
    chk("add_t5", {reg_in, Zlowout}, {16'h0002, 1'b1});
    step(1'b0, 1'b1);
    chk("add_back_t0", PCout, 1);

    // mul R3,R1
    ir = 32'h79880000;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("mul_t3", {reg_out, Yin}, {16'h0008, 1'b1});
    step(1'b0, 1'b1);
    chk("mul_t4", {reg_out, dv.alu}, {16'h0002, 13'h0008});
    step(1'b0, 1'b1);
    chk("mul_t5", {LOin, Zlowout, reg_in}, {2'b11, 16'h0});
    step(1'b0, 1'b1);
    chk("mul_t6", {HIin, Zhighout, reg_in}, {2'b11, 16'h0});

    // ld R2,0x55(R1) with three not-ready cycles in both waits
    step(1'b0, 1'b1);
    ir = 32'h01080055;
    rd_n = 0; pc_n = 0; md_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 3) ? 1'b1 : 1'b0);
      rd_n += int'(Read); pc_n += int'(PCin); md_n += int'(MDRin);
      if (i == 3) chk("ld_t1_mdrin_ready", MDRin, 1);
    end
    chk("ld_t1_reads", rd_n, 4);
    chk("ld_t1_pcin_once", pc_n, 1);
    chk("ld_t1_mdrin_once", md_n, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    rd_n = 0; md_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 3) ? 1'b1 : 1'b0);
      rd_n += int'(Read); md_n += int'(MDRin);
    end
    chk("ld_t6_reads", rd_n, 4);
    chk("ld_t6_mdrin_once", md_n, 1);
    step(1'b0, 1'b1);
    chk("ld_t7", {reg_in, MDRout}, {16'h0004, 1'b1});

    // st R5,0(R6) with two not-ready cycles in the write wait
    step(1'b0, 1'b1);
    ir = 32'h12B00000;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    chk("st_t6", {reg_out, MDRin, Read}, {16'h0020, 2'b10});
    wr_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i == 2) ? 1'b1 : 1'b0);
      wr_n += int'(Write);
    end
    chk("st_write_cycles", wr_n, 3);

    // st again, clr arrives in the middle of the write wait
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("st_wait_write_before_clr", Write, 1);
    step(1'b1, 1'b0);
    chk("st_clr_zero", 32'(dv != '0), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("st_clr_t0", PCout, 1);

    // halt opcode: HALT without illegal, held for 20 cycles
    ir = 32'hD8000000;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      chk("halt_hold", {run, illegal, 30'(dv != '0)}, 0);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // undefined opcode: HALT with illegal, or NOP on the non-halting instance
    ir = 32'hF8000000;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("ill_t3_run", {run, n_run}, 2'b11);
    step(1'b0, 1'b1);
    chk("ill_halt", {run, illegal}, 2'b01);
    chk("ill_nop_t0", {n_run, n_s}, {1'b1, 14'h1308});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("ill_hold", {run, illegal}, 2'b01);

    // Randomized run against the model
    step(1'b1, 1'b1);
    hc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == 2) hc++;
      else hc = 0;
      c = (hc > 4 || $urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      step(c, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      if ((m_mode != 1 || m_fetch) && $urandom_range(0, 3) == 0) ir = rand_ir();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
